// File: rtl/vend_pkg.sv
// Shared definitions for the coin-accumulating vending controller:
// state encoding and coin values expressed in nickel units.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'b00,
    ST_VEND   = 2'b01,
    ST_CHANGE = 2'b10
  } state_e;

  localparam logic [2:0] NICKEL_U  = 3'd1;
  localparam logic [2:0] DIME_U    = 3'd2;
  localparam logic [2:0] QUARTER_U = 3'd5;

endpackage

// File: rtl/vend_credit_fsm_coin_decode.sv
// Combinational coin classifier: flags a single legal coin, any illegal
// combination, and the nickel-unit value of the legal coin.
module coin_decode
  import vend_pkg::*;
(
  input  logic       n,
  input  logic       d,
  input  logic       q,
  input  logic       qen,
  output logic       valid,
  output logic       invalid,
  output logic [2:0] value
);

  logic any_s;
  logic multi_s;
  logic q_bad_s;

  // Classify the sampled coin inputs and look up the coin value.
  always_comb begin
    any_s   = n | d | q;
    multi_s = (n & d) | (n & q) | (d & q);
    q_bad_s = q & ~qen;
    valid   = any_s & ~multi_s & ~q_bad_s;
    invalid = any_s & ~valid;
    case ({n, d, q})
      3'b100:  value = NICKEL_U;
      3'b010:  value = DIME_U;
      3'b001:  value = QUARTER_U;
      default: value = 3'd0;
    endcase
  end

endmodule

// File: rtl/vend_credit_fsm.sv
// Vending controller: accumulates credit against PRICE, runs the vend
// handshake, then returns leftover or cancelled credit one nickel at a time.
module vend_credit_fsm
  import vend_pkg::*;
#(
  parameter int unsigned PRICE = 3,
  parameter int unsigned CW    = 4,
  parameter int unsigned QEN   = 1
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          N,
  input  logic          D,
  input  logic          Q,
  input  logic          Cancel,
  input  logic          VendAck,
  input  logic          ChangeAck,
  output logic          z,
  output logic          ChangeReq,
  output logic [CW-1:0] Credit,
  output logic          Busy,
  output logic          CoinErr
);

  localparam logic [CW:0]   PRICE_W = (CW + 1)'(PRICE);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic          QEN_B   = (QEN != 0);

  state_e        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          coin_err_q, coin_err_d;

  logic          coin_valid_s;
  logic          coin_invalid_s;
  logic          coin_any_s;
  logic [2:0]    coin_value_s;
  logic [CW:0]   sum_s;

  coin_decode u_coin_decode (
    .n       (N),
    .d       (D),
    .q       (Q),
    .qen     (QEN_B),
    .valid   (coin_valid_s),
    .invalid (coin_invalid_s),
    .value   (coin_value_s)
  );

  // Next-state, next-credit and coin-rejection decision.
  always_comb begin
    coin_any_s = coin_valid_s | coin_invalid_s;
    sum_s      = {1'b0, credit_q} + (CW + 1)'(coin_value_s);
    state_d    = state_q;
    credit_d   = credit_q;
    coin_err_d = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        // Cancel wins over a coin in the same cycle; the coin is refused.
        if (Cancel) begin
          coin_err_d = coin_any_s;
          if (credit_q != '0) begin
            state_d = ST_CHANGE;
          end else begin
            state_d = ST_ACCUM;
          end
        end else if (coin_valid_s) begin
          if (sum_s >= PRICE_W) begin
            credit_d = CW'(sum_s - PRICE_W);
            state_d  = ST_VEND;
          end else begin
            credit_d = sum_s[CW-1:0];
          end
        end else begin
          coin_err_d = coin_invalid_s;
        end
      end
      ST_VEND: begin
        coin_err_d = coin_any_s;
        if (VendAck) begin
          if (credit_q != '0) begin
            state_d = ST_CHANGE;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_VEND;
        end
      end
      ST_CHANGE: begin
        coin_err_d = coin_any_s;
        if (credit_q == '0) begin
          state_d = ST_ACCUM;
        end else if (ChangeAck) begin
          credit_d = credit_q - ONE_C;
          if (credit_q == ONE_C) begin
            state_d = ST_ACCUM;
          end else begin
            state_d = ST_CHANGE;
          end
        end else begin
          state_d = ST_CHANGE;
        end
      end
      default: begin
        state_d  = ST_ACCUM;
        credit_d = '0;
      end
    endcase
  end

  // State, credit and error flops; reset drops any outstanding credit.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= ST_ACCUM;
      credit_q   <= '0;
      coin_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      coin_err_q <= coin_err_d;
    end
  end

  assign z         = (state_q == ST_VEND);
  assign ChangeReq = (state_q == ST_CHANGE);
  assign Busy      = (state_q != ST_ACCUM);
  assign Credit    = credit_q;
  assign CoinErr   = coin_err_q;

endmodule

// File: tb/tb_vend_credit_fsm.sv
// Self-checking bench: directed vector table, hand sequences for reset and
// QEN=0, and randomized traffic against a credit/phase reference model.
module tb_vend_credit_fsm;

  localparam int PRICE = 3;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       N = 1'b0, D = 1'b0, Q = 1'b0, Cancel = 1'b0;
  logic       VendAck = 1'b0, ChangeAck = 1'b0;
  logic       z, ChangeReq, Busy, CoinErr;
  logic [3:0] Credit;

  logic       q0_q = 1'b0;
  logic       q0_zero = 1'b0;
  logic       q0_z, q0_cr, q0_busy, q0_err;
  logic [3:0] q0_credit;

  int checks = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  vend_credit_fsm #(.PRICE(3), .CW(4), .QEN(1)) dut (
    .Clock(Clock), .Resetn(Resetn), .N(N), .D(D), .Q(Q), .Cancel(Cancel),
    .VendAck(VendAck), .ChangeAck(ChangeAck), .z(z), .ChangeReq(ChangeReq),
    .Credit(Credit), .Busy(Busy), .CoinErr(CoinErr)
  );

  vend_credit_fsm #(.PRICE(3), .CW(4), .QEN(0)) dut_q0 (
    .Clock(Clock), .Resetn(Resetn), .N(q0_zero), .D(q0_zero), .Q(q0_q),
    .Cancel(q0_zero), .VendAck(q0_zero), .ChangeAck(q0_zero), .z(q0_z),
    .ChangeReq(q0_cr), .Credit(q0_credit), .Busy(q0_busy), .CoinErr(q0_err)
  );

  typedef struct {
    logic n, d, q, cancel, vack, cack;
    int   credit;
    logic z, cr, busy, err;
  } vec_t;

  vec_t vecs[$];

  // Reference model: credit in nickels plus "vend pending" / "refunding" flags.
  int m_credit;
  bit m_vend, m_refund, m_err;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input int cr_e, input logic z_e,
                               input logic chg_e, input logic busy_e, input logic err_e);
    check({tag, ".Credit"}, int'(Credit), cr_e);
    check({tag, ".z"}, int'(z), int'(z_e));
    check({tag, ".ChangeReq"}, int'(ChangeReq), int'(chg_e));
    check({tag, ".Busy"}, int'(Busy), int'(busy_e));
    check({tag, ".CoinErr"}, int'(CoinErr), int'(err_e));
  endtask

  task automatic model_step(input bit n, input bit d, input bit q, input bit cancel,
                            input bit vack, input bit cack);
    int ncoins;
    int value;
    ncoins = int'(n) + int'(d) + int'(q);
    m_err = 1'b0;
    if (m_vend) begin
      m_err = (ncoins != 0);
      if (vack) begin
        m_vend   = 1'b0;
        m_refund = (m_credit > 0);
      end
    end else if (m_refund) begin
      m_err = (ncoins != 0);
      if (cack) begin
        m_credit = m_credit - 1;
        if (m_credit == 0) m_refund = 1'b0;
      end
    end else if (cancel) begin
      m_err = (ncoins != 0);
      if (m_credit > 0) m_refund = 1'b1;
    end else if (ncoins == 1) begin
      value = n ? 1 : (d ? 2 : 5);
      m_credit = m_credit + value;
      if (m_credit >= PRICE) begin
        m_credit = m_credit - PRICE;
        m_vend   = 1'b1;
      end
    end else begin
      m_err = (ncoins != 0);
    end
  endtask

  task automatic add_vec(input logic n, input logic d, input logic q, input logic cancel,
                         input logic vack, input logic cack, input int credit,
                         input logic z_e, input logic cr, input logic busy, input logic err);
    vec_t v;
    v.n = n; v.d = d; v.q = q; v.cancel = cancel; v.vack = vack; v.cack = cack;
    v.credit = credit; v.z = z_e; v.cr = cr; v.busy = busy; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic n, input logic d, input logic q, input logic cancel,
                       input logic vack, input logic cack);
    @(negedge Clock);
    N = n; D = d; Q = q; Cancel = cancel; VendAck = vack; ChangeAck = cack;
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Resetn = 1'b0;
    N = 1'b0; D = 1'b0; Q = 1'b0; Cancel = 1'b0; VendAck = 1'b0; ChangeAck = 1'b0;
    q0_q = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
  endtask

  initial begin
    //       n d q  can vak cak  credit z  cr busy err
    add_vec(1,0,0, 0,0,0, 1, 0,0,0,0);   // N
    add_vec(1,0,0, 0,0,0, 2, 0,0,0,0);   // N
    add_vec(1,0,0, 0,0,0, 0, 1,0,1,0);   // N reaches price
    add_vec(0,0,0, 0,0,0, 0, 1,0,1,0);   // z held
    add_vec(0,0,0, 0,1,0, 0, 0,0,0,0);   // VendAck, no change
    add_vec(0,1,0, 0,0,0, 2, 0,0,0,0);   // D
    add_vec(0,1,0, 0,0,0, 1, 1,0,1,0);   // D -> vend, remainder 1
    add_vec(0,0,0, 0,1,0, 1, 0,1,1,0);   // VendAck -> change
    add_vec(0,0,0, 0,0,1, 0, 0,0,0,0);   // ChangeAck -> done
    add_vec(0,0,1, 0,0,0, 2, 1,0,1,0);   // Q from 0
    add_vec(0,0,0, 0,0,1, 2, 1,0,1,0);   // ChangeAck in VEND ignored
    add_vec(0,0,0, 0,1,0, 2, 0,1,1,0);   // VendAck
    add_vec(0,0,0, 0,0,1, 1, 0,1,1,0);   // ChangeAck
    add_vec(0,0,0, 0,0,1, 0, 0,0,0,0);   // ChangeAck -> ACCUM
    add_vec(1,1,0, 0,0,0, 0, 0,0,0,1);   // N+D rejected
    add_vec(0,0,0, 0,0,0, 0, 0,0,0,0);   // CoinErr single pulse
    add_vec(0,1,0, 0,0,0, 2, 0,0,0,0);   // D
    add_vec(0,0,0, 1,0,0, 2, 0,1,1,0);   // Cancel -> refund
    add_vec(1,0,0, 0,0,0, 2, 0,1,1,1);   // N during CHANGE rejected
    add_vec(0,0,0, 1,1,0, 2, 0,1,1,0);   // Cancel/VendAck ignored in CHANGE
    add_vec(0,0,0, 0,0,1, 1, 0,1,1,0);
    add_vec(0,0,0, 0,0,1, 0, 0,0,0,0);
    add_vec(0,0,0, 0,0,1, 0, 0,0,0,0);   // stray ChangeAck in ACCUM
    add_vec(0,1,0, 0,0,0, 2, 0,0,0,0);   // D
    add_vec(0,1,0, 1,0,0, 2, 0,1,1,1);   // Cancel + D: refund, coin rejected
    add_vec(0,0,0, 0,0,1, 1, 0,1,1,0);
    add_vec(0,0,0, 0,0,1, 0, 0,0,0,0);
    add_vec(0,0,0, 1,0,0, 0, 0,0,0,0);   // Cancel with no credit
    add_vec(0,1,0, 0,0,0, 2, 0,0,0,0);   // D
    add_vec(1,0,0, 0,0,0, 0, 1,0,1,0);   // N -> exact price
    add_vec(0,1,0, 0,0,0, 0, 1,0,1,1);   // coin during VEND rejected
    add_vec(0,0,0, 1,1,0, 0, 0,0,0,0);   // VendAck -> ACCUM, Cancel ignored
    add_vec(0,1,0, 0,0,0, 2, 0,0,0,0);   // D
    add_vec(0,0,1, 0,0,0, 4, 1,0,1,0);   // Q from 2: 7-3=4
    add_vec(0,0,0, 0,1,0, 4, 0,1,1,0);

    Resetn = 1'b0;
    #12;
    check_outputs("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].n, vecs[i].d, vecs[i].q, vecs[i].cancel, vecs[i].vack, vecs[i].cack);
      check_outputs($sformatf("vec%0d", i), vecs[i].credit, vecs[i].z, vecs[i].cr,
                    vecs[i].busy, vecs[i].err);
    end

    // Asynchronous reset while refunding two nickels.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_outputs("pre_async_rst", 2, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge Clock);
    Cancel = 1'b0;
    #2;
    Resetn = 1'b0;
    #1;
    check_outputs("async_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge Clock);
    Resetn = 1'b1;

    // Quarter with QEN=0 is an invalid coin.
    @(negedge Clock);
    q0_q = 1'b1;
    @(posedge Clock);
    #1;
    check("qen0.CoinErr", int'(q0_err), 1);
    check("qen0.Credit", int'(q0_credit), 0);
    check("qen0.Busy", int'(q0_busy), 0);
    @(negedge Clock);
    q0_q = 1'b0;
    @(posedge Clock);
    #1;
    check("qen0.CoinErr_clear", int'(q0_err), 0);

    // Randomized traffic against the reference model.
    do_reset();
    m_credit = 0; m_vend = 1'b0; m_refund = 1'b0; m_err = 1'b0;
    for (int c = 0; c < 400; c++) begin
      bit rn, rd, rq, rc, rva, rca;
      rn  = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 9) < 2);
      rq  = ($urandom_range(0, 9) < 1);
      rc  = ($urandom_range(0, 19) < 2);
      rva = ($urandom_range(0, 9) < 4);
      rca = ($urandom_range(0, 9) < 5);
      drive(rn, rd, rq, rc, rva, rca);
      model_step(rn, rd, rq, rc, rva, rca);
      check_outputs($sformatf("rand%0d", c), m_credit, m_vend, m_refund,
                    m_vend | m_refund, m_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
